// File: rtl/divider_4_seq.sv
// rtl/divider_4_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
//
// Computes Q = A / B and R = A % B for WIDTH-bit unsigned operands.
// Optional feature macro: DIVIDER_ZERO_CHECK_EN
//   defined   : a start with B == 0 skips the iteration, finishes at the accepting edge
//               and raises div_by_zero until the next accepted start.
//   undefined : B == 0 runs the normal sequence (giving Q = all ones, R = A);
//               div_by_zero is tied low.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous reset, active low
//   start        in   1      request a divide; sampled only in IDLE
//   A            in   WIDTH  dividend, latched at the accepting edge
//   B            in   WIDTH  divisor, latched at the accepting edge
//   Q            out  WIDTH  quotient, registered, held until the next result
//   R            out  WIDTH  remainder, registered, held until the next result
//   busy         out  1      high while iterating (RUN)
//   done         out  1      one-cycle pulse when Q/R are updated
//   div_by_zero  out  1      B was 0 for the current result

module divider_4_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic             zero_fast;

`ifdef DIVIDER_ZERO_CHECK_EN
  assign zero_fast = (B == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // One restoring step. The partial remainder always stays below dvs (or below
  // 2^k after k steps when dvs == 0), so rem_sh < 2*dvs and a successful trial
  // subtract never sets bit WIDTH of diff; that bit is therefore the borrow.
  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs};
    ge       = ~diff[WIDTH];
    rem_step = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_step = {dvd[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = zero_fast ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      Q   <= '0;
      R   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd <= A;
            dvs <= B;
            rem <= '0;
            cnt <= CW'(WIDTH);
            if (zero_fast) begin
              Q <= '1;
              R <= A;
            end
          end
        end
        RUN: begin
          dvd <= dvd_step;
          rem <= rem_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Q <= dvd_step;
            R <= rem_step;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIVIDER_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      div_by_zero <= zero_fast;
    end
  end
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_divider_4_seq.sv
// tb/tb_divider_4_seq.sv - directed self-checking bench for divider_4_seq

module tb_divider_4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  divider_4_seq #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one divide (start for one cycle), wait for done, check everything.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er);
    int lat;
    int busy_cnt;
    int exp_lat;
    bit fast;
    fast    = ZC && (b == 4'd0);
    exp_lat = fast ? 0 : 4;
    start = 1'b1;
    A     = a;
    B     = b;
    step();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      step();
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, fast ? 0 : 4);
    check({tag, " Q"}, Q, eq);
    check({tag, " R"}, R, er);
    check({tag, " div_by_zero"}, div_by_zero, (fast ? 1 : 0));
    step();
    check({tag, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = 4'd0;
    B     = 4'd0;
    #2;
    check("reset Q", Q, 0);
    check("reset R", R, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_by_zero", div_by_zero, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed vectors.
    run_op("13/4", 4'd13, 4'd4, 4'd3, 4'd1);
    run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0);
    run_op("3/7", 4'd3, 4'd7, 4'd0, 4'd3);
    run_op("15/15", 4'd15, 4'd15, 4'd1, 4'd0);
    run_op("9/0", 4'd9, 4'd0, 4'd15, 4'd9);

    // start held high through RUN and DONE with operands changing.
    start = 1'b1;
    A     = 4'd13;
    B     = 4'd4;
    step();                                   // E0: 13/4 accepted
    A = 4'd7;
    B = 4'd2;
    check("held busy_after_accept", busy, 1);
    step(); step(); step();                   // E1..E3
    check("held still_busy_E3", busy, 1);
    step();                                   // E4
    check("held done_E4", done, 1);
    check("held Q first_op", Q, 3);
    check("held R first_op", R, 1);
    step();                                   // E5: DONE -> IDLE, start ignored
    check("held idle_done_E5", done, 0);
    check("held idle_busy_E5", busy, 0);
    step();                                   // E6: 7/2 accepted
    start = 1'b0;
    check("held reaccept_busy_E6", busy, 1);
    check("held Q kept_during_run", Q, 3);
    step(); step(); step(); step();           // E7..E10
    check("held second_done", done, 1);
    check("held second_Q", Q, 3);
    check("held second_R", R, 1);
    step();

    // Asynchronous reset after two RUN steps.
    run_op("14/3", 4'd14, 4'd3, 4'd4, 4'd2);
    start = 1'b1;
    A     = 4'd13;
    B     = 4'd4;
    step();                                   // E0
    start = 1'b0;
    step(); step();                           // two RUN steps
    check("midrst busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst Q", Q, 0);
    check("midrst R", R, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst div_by_zero", div_by_zero, 0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst stays_idle", busy, 0);
    run_op("10/3 after reset", 4'd10, 4'd3, 4'd3, 4'd1);

    // Exhaustive sweep against hand arithmetic.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] eq;
        logic [3:0] er;
        logic [3:0] av;
        logic [3:0] bv;
        av = a[3:0];
        bv = b[3:0];
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? av : 4'(a % b);
        run_op($sformatf("sweep %0d/%0d", a, b), av, bv, eq, er);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
